// File: rtl/ddr3_burst_read_engine_if.sv
// Bus bundle for the DDR3 burst read engine: EMIF Avalon-MM read port,
// command strobe/status and the consumer-side FIFO pop port.
interface ddr3_burst_read_engine_if #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 22,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 32
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam int BA_W  = ADDR_W + OFS_W;
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    // EMIF side
    logic                      ddr3_emif_ready;
    logic                      ddr3_emif_read;
    logic [ADDR_W-1:0]         ddr3_emif_addr;
    logic [BC_W-1:0]           ddr3_emif_burst_count;
    logic [DATA_W-1:0]         ddr3_emif_read_data;
    logic                      ddr3_emif_rddata_valid;

    // command / status
    logic                      start_in;
    logic [BA_W-1:0]           start_addr_in;
    logic [LEN_W-1:0]          byte_len_in;
    logic                      busy_out;
    logic                      done_out;
    logic                      error_out;

    // consumer side
    logic                      read_req_in;
    logic                      data_ready_out;
    logic [DATA_W+BYTES-1:0]   read_data_out;
    logic                      read_data_valid_out;

    // engine side
    modport master (
        input  ddr3_emif_ready, ddr3_emif_read_data, ddr3_emif_rddata_valid,
        input  start_in, start_addr_in, byte_len_in, read_req_in,
        output ddr3_emif_read, ddr3_emif_addr, ddr3_emif_burst_count,
        output busy_out, done_out, error_out,
        output data_ready_out, read_data_out, read_data_valid_out
    );

    // environment side (EMIF model, command source, consumer)
    modport slave (
        output ddr3_emif_ready, ddr3_emif_read_data, ddr3_emif_rddata_valid,
        output start_in, start_addr_in, byte_len_in, read_req_in,
        input  ddr3_emif_read, ddr3_emif_addr, ddr3_emif_burst_count,
        input  busy_out, done_out, error_out,
        input  data_ready_out, read_data_out, read_data_valid_out
    );
endinterface

// File: rtl/ddr3_burst_read_engine.sv
// DDR3 burst read engine: splits a byte-addressed read into credit-limited
// EMIF bursts, tags each returned word with a byte-valid mask and buffers
// the words in a FIFO with a registered (show-ahead-off) output.
module ddr3_burst_read_engine #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 22,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 128,
    parameter int LEN_W      = 32
) (
    input  logic ddr3_emif_clk,
    input  logic ddr3_emif_rst,
    ddr3_burst_read_engine_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam int BA_W  = ADDR_W + OFS_W;
    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 1;
    localparam int WL_W  = LEN_W + 1;
    localparam int FW    = DATA_W + BYTES;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state;

    logic [WL_W-1:0]   words_left, total_m1, beat_k;
    logic [BYTES-1:0]  first_mask, last_mask, beat_mask;
    logic [CNT_W-1:0]  outstanding, fifo_used;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FW-1:0]     fifo_mem [FIFO_DEPTH];

    // command decode: offset in first word, end offset and word count
    logic [OFS_W-1:0]  cmd_ofs, cmd_end;
    logic [WL_W-1:0]   cmd_sum, cmd_total;
    assign cmd_ofs   = bus.start_addr_in[OFS_W-1:0];
    assign cmd_sum   = {1'b0, bus.byte_len_in} + WL_W'(cmd_ofs);
    assign cmd_end   = cmd_sum[OFS_W-1:0];
    assign cmd_total = WL_W'(cmd_sum[WL_W-1:OFS_W]) + WL_W'(|cmd_end);

    // per-cycle events
    logic accept, push, stray, pop;
    assign accept = bus.ddr3_emif_read && bus.ddr3_emif_ready;
    assign push   = bus.ddr3_emif_rddata_valid && (outstanding != '0);
    assign stray  = bus.ddr3_emif_rddata_valid && (outstanding == '0);
    assign pop    = bus.read_req_in && (fifo_used != '0);

    // next-cycle view of the counters, so the next burst can be presented
    // the cycle right after an accept when credit already allows it
    logic [WL_W-1:0]   wl_nxt;
    logic [CNT_W-1:0]  out_nxt, used_nxt, acc_beats;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BC_W-1:0]   blen_nxt;
    logic [CR_W-1:0]   credit_nxt;
    logic              eligible;
    assign acc_beats  = accept ? CNT_W'(bus.ddr3_emif_burst_count) : '0;
    assign wl_nxt     = accept ? words_left - WL_W'(bus.ddr3_emif_burst_count) : words_left;
    assign out_nxt    = outstanding + acc_beats - CNT_W'(push);
    assign used_nxt   = fifo_used + CNT_W'(push) - CNT_W'(pop);
    assign addr_nxt   = accept ? bus.ddr3_emif_addr + ADDR_W'(bus.ddr3_emif_burst_count)
                               : bus.ddr3_emif_addr;
    assign blen_nxt   = (wl_nxt >= WL_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : wl_nxt[BC_W-1:0];
    assign credit_nxt = CR_W'(FIFO_DEPTH) - {1'b0, used_nxt} - {1'b0, out_nxt};
    assign eligible   = (wl_nxt != '0) && (credit_nxt >= CR_W'(blen_nxt));

    // byte mask of the beat being written: trim first and last words
    always_comb begin
        beat_mask = '1;
        if (beat_k == '0)     beat_mask = beat_mask & first_mask;
        if (beat_k == total_m1) beat_mask = beat_mask & last_mask;
    end

    assign bus.data_ready_out = (fifo_used != '0);

    // control FSM: command latch, burst issue, completion and error flag
    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            state                     <= IDLE;
            words_left                <= '0;
            total_m1                  <= '0;
            beat_k                    <= '0;
            first_mask                <= '0;
            last_mask                 <= '0;
            outstanding               <= '0;
            bus.ddr3_emif_read        <= 1'b0;
            bus.ddr3_emif_addr        <= '0;
            bus.ddr3_emif_burst_count <= '0;
            bus.busy_out              <= 1'b0;
            bus.done_out              <= 1'b0;
            bus.error_out             <= 1'b0;
        end else begin
            bus.done_out <= 1'b0;
            outstanding  <= out_nxt;
            words_left   <= wl_nxt;
            if (push) beat_k <= beat_k + WL_W'(1);
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        bus.error_out <= 1'b0;
                        if (bus.byte_len_in == '0) begin
                            bus.done_out <= 1'b1;
                        end else begin
                            state              <= ISSUE;
                            bus.busy_out       <= 1'b1;
                            words_left         <= cmd_total;
                            total_m1           <= cmd_total - WL_W'(1);
                            beat_k             <= '0;
                            first_mask         <= {BYTES{1'b1}} << cmd_ofs;
                            last_mask          <= (cmd_end == '0) ? {BYTES{1'b1}}
                                                  : ~({BYTES{1'b1}} << cmd_end);
                            bus.ddr3_emif_addr <= bus.start_addr_in[BA_W-1:OFS_W];
                        end
                    end
                end
                ISSUE: begin
                    // a presented command stays frozen until the EMIF takes it
                    if (!(bus.ddr3_emif_read && !bus.ddr3_emif_ready)) begin
                        bus.ddr3_emif_addr        <= addr_nxt;
                        bus.ddr3_emif_burst_count <= blen_nxt;
                        bus.ddr3_emif_read        <= eligible;
                        if (wl_nxt == '0) begin
                            bus.ddr3_emif_read <= 1'b0;
                            state              <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (push && beat_k == total_m1) begin
                        bus.done_out <= 1'b1;
                        bus.busy_out <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // a beat nobody asked for is dropped and flagged
            if (stray) bus.error_out <= 1'b1;
        end
    end

    // FIFO storage write port (no reset needed on the array)
    always_ff @(posedge ddr3_emif_clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.ddr3_emif_read_data, beat_mask};
    end

    // FIFO pointers, occupancy and registered read port
    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            fifo_used               <= '0;
            bus.read_data_out       <= '0;
            bus.read_data_valid_out <= 1'b0;
        end else begin
            fifo_used               <= used_nxt;
            bus.read_data_valid_out <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr            <= rd_ptr + PTR_W'(1);
                bus.read_data_out <= fifo_mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_ddr3_burst_read_engine.sv
// Scoreboard bench for ddr3_burst_read_engine: directed commands push the
// expected EMIF commands and FIFO words into queues; monitors pop and compare.
module tb_ddr3_burst_read_engine;
    localparam int DATA_W     = 256;
    localparam int ADDR_W     = 22;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 128;
    localparam int LEN_W      = 32;
    localparam int BYTES      = DATA_W / 8;
    localparam int OFS_W      = $clog2(BYTES);
    localparam int BA_W       = ADDR_W + OFS_W;
    localparam int BC_W       = $clog2(MAX_BURST) + 1;
    localparam int FW         = DATA_W + BYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ddr3_burst_read_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) bus ();

    ddr3_burst_read_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST),
        .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .ddr3_emif_clk(clk),
        .ddr3_emif_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [FW-1:0]          exp_q[$];
    logic [ADDR_W+BC_W-1:0] cmd_q[$];
    logic [ADDR_W-1:0]      pend_q[$];
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_beats = 0;
    int stray_req = 0;

    function automatic logic [DATA_W-1:0] word_data(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {10'h2A5, a};
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_word(input logic [ADDR_W-1:0] a, input logic [BYTES-1:0] m);
        exp_q.push_back({word_data(a), m});
    endtask

    task automatic exp_cmd(input logic [ADDR_W-1:0] a, input logic [BC_W-1:0] bc);
        cmd_q.push_back({a, bc});
    endtask

    task automatic start_cmd(input logic [BA_W-1:0] a, input logic [LEN_W-1:0] l);
        tick();
        bus.start_in      = 1'b1;
        bus.start_addr_in = a;
        bus.byte_len_in   = l;
        tick();
        bus.start_in      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done_out && n < budget);
        chk({name, "_done"}, bus.done_out, 1);
        chk({name, "_busy_clr"}, bus.busy_out, 0);
        @(negedge clk);
        chk({name, "_done_pulse"}, bus.done_out, 0);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.data_ready_out) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_words_left"}, exp_q.size(), 0);
        chk({name, "_cmds_left"}, cmd_q.size(), 0);
    endtask

    // monitor: FIFO output words and accepted EMIF commands
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.read_data_valid_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_word actual=%h required=none", bus.read_data_out);
                end else begin
                    logic [FW-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.read_data_out !== e) begin
                        errors++;
                        $display("FAIL fifo_word actual=%h required=%h", bus.read_data_out, e);
                    end
                end
            end
            if (bus.ddr3_emif_read && bus.ddr3_emif_ready) begin
                n_acc++;
                n_beats += int'(bus.ddr3_emif_burst_count);
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL emif_cmd actual=%0h/%0d required=none",
                             bus.ddr3_emif_addr, bus.ddr3_emif_burst_count);
                end else begin
                    logic [ADDR_W+BC_W-1:0] c;
                    c = cmd_q.pop_front();
                    if ({bus.ddr3_emif_addr, bus.ddr3_emif_burst_count} !== c) begin
                        errors++;
                        $display("FAIL emif_cmd actual=%0h/%0d required=%0h/%0d",
                                 bus.ddr3_emif_addr, bus.ddr3_emif_burst_count,
                                 c[ADDR_W+BC_W-1:BC_W], c[BC_W-1:0]);
                    end
                end
                for (int i = 0; i < int'(bus.ddr3_emif_burst_count); i++)
                    pend_q.push_back(bus.ddr3_emif_addr + ADDR_W'(i));
            end
        end
    end

    // EMIF read-return model: one beat per cycle with a gap every 5th cycle
    initial begin
        int cyc = 0;
        bus.ddr3_emif_rddata_valid = 1'b0;
        bus.ddr3_emif_read_data    = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.ddr3_emif_rddata_valid = 1'b0;
            if (stray_req > 0) begin
                bus.ddr3_emif_rddata_valid = 1'b1;
                bus.ddr3_emif_read_data    = '1;
                stray_req--;
            end else if (pend_q.size() != 0 && (cyc % 5) != 0) begin
                bus.ddr3_emif_rddata_valid = 1'b1;
                bus.ddr3_emif_read_data    = word_data(pend_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int beats0;
        int n;
        bus.start_in        = 1'b0;
        bus.start_addr_in   = '0;
        bus.byte_len_in     = '0;
        bus.read_req_in     = 1'b1;
        bus.ddr3_emif_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", bus.ddr3_emif_read, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_done", bus.done_out, 0);
        chk("rst_error", bus.error_out, 0);
        chk("rst_dready", bus.data_ready_out, 0);
        chk("rst_dvalid", bus.read_data_valid_out, 0);
        tick();
        rst = 1'b0;

        // aligned 2-word read
        exp_cmd(22'h2, 2);
        exp_word(22'h2, 32'hFFFFFFFF);
        exp_word(22'h3, 32'hFFFFFFFF);
        start_cmd(27'h40, 64);
        @(negedge clk);
        chk("t1_busy", bus.busy_out, 1);
        chk("t1_read_early", bus.ddr3_emif_read, 0);
        @(negedge clk);
        chk("t1_read", bus.ddr3_emif_read, 1);
        wait_done("t1", 60);
        chk("t1_error", bus.error_out, 0);
        wait_empty("t1", 60);

        // unaligned 3-word read with partial first/last words
        exp_cmd(22'h1, 3);
        exp_word(22'h1, 32'hFFFFFFE0);
        exp_word(22'h2, 32'hFFFFFFFF);
        exp_word(22'h3, 32'h00000001);
        start_cmd(27'h25, 60);
        wait_done("t2", 60);
        wait_empty("t2", 60);

        // zero length: immediate done, no EMIF traffic
        acc0 = n_acc;
        start_cmd(27'h123, 0);
        @(negedge clk);
        chk("t3_done", bus.done_out, 1);
        chk("t3_busy", bus.busy_out, 0);
        @(negedge clk);
        chk("t3_done_pulse", bus.done_out, 0);
        repeat (5) @(negedge clk);
        chk("t3_no_cmd", n_acc - acc0, 0);

        // 40 words, EMIF not ready for the first command
        tick();
        bus.ddr3_emif_ready = 1'b0;
        exp_cmd(22'h80, 16);
        exp_cmd(22'h90, 16);
        exp_cmd(22'hA0, 8);
        for (int i = 0; i < 40; i++) exp_word(22'h80 + ADDR_W'(i), '1);
        start_cmd(27'h1000, 40 * 32);
        n = 0;
        while (!bus.ddr3_emif_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_read_up", bus.ddr3_emif_read, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_read", bus.ddr3_emif_read, 1);
            chk("t4_hold_addr", bus.ddr3_emif_addr, 22'h80);
            chk("t4_hold_bc", bus.ddr3_emif_burst_count, 16);
        end
        tick();
        bus.ddr3_emif_ready = 1'b1;
        wait_done("t4", 300);
        wait_empty("t4", 100);

        // 200 words with the consumer stalled: credit caps requests at 128
        tick();
        bus.read_req_in = 1'b0;
        beats0 = n_beats;
        for (int i = 0; i < 12; i++) exp_cmd(ADDR_W'(i * 16), 16);
        exp_cmd(22'd192, 8);
        for (int i = 0; i < 200; i++) exp_word(ADDR_W'(i), '1);
        start_cmd(27'h0, 200 * 32);
        repeat (300) @(negedge clk);
        chk("t5_req_beats", n_beats - beats0, 128);
        chk("t5_stall_read", bus.ddr3_emif_read, 0);
        chk("t5_dready", bus.data_ready_out, 1);
        tick();
        bus.read_req_in = 1'b1;
        wait_done("t5", 2000);
        wait_empty("t5", 200);

        // reset mid-burst, then stray returns
        acc0 = n_acc;
        exp_cmd(22'h100, 16);
        exp_cmd(22'h110, 16);
        for (int i = 0; i < 32; i++) exp_word(22'h100 + ADDR_W'(i), '1);
        start_cmd(27'h2000, 32 * 32);
        n = 0;
        while (n_acc == acc0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_cmd", n_acc - acc0, 1);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        pend_q.delete();
        exp_q.delete();
        cmd_q.delete();
        #1;
        chk("t6_rst_read", bus.ddr3_emif_read, 0);
        chk("t6_rst_addr", bus.ddr3_emif_addr, 0);
        chk("t6_rst_bc", bus.ddr3_emif_burst_count, 0);
        chk("t6_rst_busy", bus.busy_out, 0);
        chk("t6_rst_done", bus.done_out, 0);
        chk("t6_rst_dready", bus.data_ready_out, 0);
        chk("t6_rst_dvalid", bus.read_data_valid_out, 0);
        chk("t6_rst_rdata", |bus.read_data_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        stray_req = 2;
        repeat (6) @(negedge clk);
        chk("t6_error", bus.error_out, 1);
        chk("t6_fifo_empty", bus.data_ready_out, 0);
        chk("t6_busy_idle", bus.busy_out, 0);

        // next command clears the error and runs normally
        exp_cmd(22'h2, 2);
        exp_word(22'h2, 32'hFFFFFFFF);
        exp_word(22'h3, 32'hFFFFFFFF);
        start_cmd(27'h40, 64);
        @(negedge clk);
        chk("t7_error_clr", bus.error_out, 0);
        wait_done("t7", 60);
        wait_empty("t7", 60);
        chk("t7_error", bus.error_out, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
